// File: rtl/layer_sequencer.sv
// Frame-level sequencer: launches each pipeline stage in turn, waits for its
// completion pulse under a per-stage watchdog, and reports frame done or a stage timeout.
module layer_sequencer #(
    parameter int  NUM_STAGES     = 3,
    parameter int  TIMEOUT_CYCLES = 1048576,
    parameter int  FRAME_W        = 16,
    localparam int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  err_clr,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [IDX_W-1:0]      err_stage,
    output logic [FRAME_W-1:0]    frame_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FINISH,
        FAULT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WD_W-1:0]  wd;

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [IDX_W-1:0] i);
        return NUM_STAGES'(1) << i;
    endfunction

    // Outputs are registered alongside the state they belong to, so stage_start,
    // busy, done and error are all valid exactly during the matching state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            wd          <= '0;
            err_stage   <= '0;
            frame_count <= '0;
            stage_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            stage_start <= '0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        state       <= LAUNCH;
                        stage_start <= stage_onehot('0);
                        busy        <= 1'b1;
                    end
                end
                LAUNCH: begin
                    wd <= '0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Priority: abort, then the stage's own done, then the watchdog.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (stage_done[idx]) begin
                        if (idx == LAST_IDX) begin
                            state       <= FINISH;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            frame_count <= frame_count + 1'b1;
                        end else begin
                            idx         <= idx + 1'b1;
                            state       <= LAUNCH;
                            stage_start <= stage_onehot(idx + 1'b1);
                        end
                    end else if (wd == WD_LAST) begin
                        state     <= FAULT;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_stage <= idx;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                FAULT: begin
                    if (err_clr) begin
                        state <= IDLE;
                        error <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: per-frame event timeline predicted from stage answer delays.
module tb_layer_sequencer;

    localparam int NS = 3;
    localparam int TO = 8;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          err_clr;
    logic [NS-1:0] stage_start;
    logic [NS-1:0] stage_done;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_stage;
    logic [FW-1:0] frame_count;

    int n_assert = 0;
    int n_fail   = 0;
    int fc_model = 0;

    layer_sequencer #(
        .NUM_STAGES    (NS),
        .TIMEOUT_CYCLES(TO),
        .FRAME_W       (FW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .err_clr    (err_clr),
        .stage_start(stage_start),
        .stage_done (stage_done),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_stage  (err_stage),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stage_start"}, 32'(stage_start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_err_stage"}, 32'(err_stage), 32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    // One frame: stage k answers d[k] cycles after its start pulse (d > TO means never).
    // abort_at: 0 none, -1 random cycle inside the frame, >0 that cycle.
    // noise: spurious stage_done[NS-1] during stage 0 WAIT plus start/abort pulses while busy/faulted.
    task automatic run_frame(input int d0, input int d1, input int d2,
                             input int abort_at, input bit noise, input int clr_hold);
        int d[NS];
        int ts[NS];
        int nk, fin, fcyc, fstage, t, a, e, endb, last, startlim;
        logic [NS-1:0] exp_ss;
        logic [NS-1:0] sd;
        d[0] = d0; d[1] = d1; d[2] = d2;
        t = 1; nk = 0; fin = 0; fcyc = 0; fstage = 0;
        for (int k = 0; k < NS; k++) begin
            ts[k] = t;
            nk = k + 1;
            if (d[k] > TO) begin
                fcyc   = ts[k] + TO + 1;
                fstage = k;
                break;
            end
            t = ts[k] + d[k] + 1;
        end
        if (fcyc == 0) fin = t;
        if (abort_at < 0) a = $urandom_range(1, ((fin > 0) ? fin : fcyc) - 1);
        else              a = abort_at;
        e        = fcyc + clr_hold;
        endb     = (a > 0) ? a + 1 : ((fin > 0) ? fin : fcyc);
        last     = (a > 0) ? a + 2 : ((fin > 0) ? fin + 2 : e + 2);
        startlim = (a > 0) ? a : ((fin > 0) ? fin : e);

        start = 1'b1; abort = 1'b0; err_clr = 1'b0; stage_done = '0;
        step();
        for (int c = 1; c <= last; c++) begin
            exp_ss = '0;
            for (int k = 0; k < nk; k++)
                if (ts[k] == c && (a == 0 || c <= a)) exp_ss[k] = 1'b1;
            chk("stage_start", 32'(stage_start), 32'(exp_ss));
            chk("busy", 32'(busy), 32'(c < endb));
            chk("done", 32'(done), 32'(a == 0 && fin == c));
            chk("error", 32'(error), 32'(a == 0 && fcyc > 0 && c >= fcyc && c <= e));
            if (a == 0 && fcyc > 0 && c >= fcyc && c <= e)
                chk("err_stage", 32'(err_stage), 32'(fstage));

            sd = '0;
            for (int k = 0; k < nk; k++)
                if (d[k] <= TO && c == ts[k] + d[k] && (a == 0 || c <= a)) sd[k] = 1'b1;
            if (noise && c == ts[0] + 1) sd[NS-1] = 1'b1;
            stage_done = sd;
            start   = noise && c <= startlim && (($urandom_range(0, 1) == 1) || c == fin);
            abort   = (a > 0 && c == a) ||
                      (noise && a == 0 && fcyc > 0 && c >= fcyc && c <= e && ($urandom_range(0, 1) == 1));
            err_clr = (a == 0 && fcyc > 0 && c == e);
            step();
        end
        start = 1'b0; abort = 1'b0; err_clr = 1'b0; stage_done = '0;
        if (a == 0 && fin > 0) fc_model = (fc_model + 1) % (1 << FW);
        chk("frame_count", 32'(frame_count), 32'(fc_model));
    endtask

    initial begin
        int r0, r1, r2;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; err_clr = 1'b0; stage_done = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        run_frame(5, 5, 5, 0, 1'b0, 0);     // nominal timing: starts @1,7,13, done @19
        run_frame(3, 20, 5, 0, 1'b0, 2);    // stage 1 times out
        run_frame(TO, TO, TO, 0, 1'b0, 0);  // each answer on the last watchdog cycle
        run_frame(4, 6, 4, 10, 1'b0, 0);    // abort in stage 1 WAIT
        run_frame(2, 2, 2, 0, 1'b0, 0);
        run_frame(1, 1, 1, 1, 1'b0, 0);     // abort during the first LAUNCH
        run_frame(3, 4, 2, 0, 1'b1, 0);     // spurious done and start pulses, wraps count
        run_frame(1, 1, 1, 0, 1'b0, 0);
        run_frame(6, 3, 20, 0, 1'b1, 3);    // timeout on last stage with noise while faulted

        for (int i = 0; i < 10; i++) begin
            r0 = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(1, TO);
            r1 = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(1, TO);
            r2 = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(1, TO);
            run_frame(r0, r1, r2, ($urandom_range(0, 3) == 0) ? -1 : 0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of a frame.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fc_model = 0;
        step();
        step();
        chk_all_zero("post_reset");
        run_frame(2, 3, 4, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of pipeline stages sequenced (conv, maxpool, dense); legal range 1..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: per-stage watchdog limit in clk cycles; legal minimum 2.
REQ-003 Parameter FRAME_W, default 16: width of the frame counter.
REQ-004 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: frame start request, sampled only in IDLE.
REQ-007 Port abort, input, 1: cancels the frame in progress.
REQ-008 Port err_clr, input, 1: clears FAULT.
REQ-009 Port stage_start, output, NUM_STAGES: one-cycle start pulse per stage.
REQ-010 Port stage_done, input, NUM_STAGES: one-cycle completion pulse per stage.
REQ-011 Port busy, output, 1: high in LAUNCH and WAIT.
REQ-012 Port done, output, 1: one-cycle frame-complete pulse.
REQ-013 Port error, output, 1: high in FAULT.
REQ-014 Port err_stage, output, $clog2(NUM_STAGES) (min 1): index of the stage that timed out; valid while error is high.
REQ-015 Port frame_count, output, FRAME_W: number of completed frames.

Function
REQ-016 States: IDLE, LAUNCH, WAIT, FINISH, FAULT; stage index idx; watchdog counter wd, wide enough for TIMEOUT_CYCLES-1.
REQ-017 IDLE: when start=1, set idx=0 and go to LAUNCH; otherwise stay in IDLE.
REQ-018 LAUNCH: stage_start[idx]=1 for this one cycle only; all other stage_start bits are 0; clear wd; go to WAIT.
REQ-019 stage_start and done are decoded from registered state/idx only; neither has a combinational path from any input.
REQ-020 WAIT, stage_done[idx]=1, idx<NUM_STAGES-1: increment idx and go to LAUNCH.
REQ-021 WAIT, stage_done[idx]=1, idx=NUM_STAGES-1: go to FINISH.
REQ-022 WAIT, no done, wd=TIMEOUT_CYCLES-1: go to FAULT and latch err_stage=idx.
REQ-023 WAIT, no done, wd below the limit: increment wd.
REQ-024 Simultaneous done and timeout in WAIT: done wins; no fault.
REQ-025 stage_done bits other than idx, and any stage_done outside WAIT, are ignored.
REQ-026 FINISH: done=1 for exactly one cycle; frame_count increments (wraps modulo 2^FRAME_W); go to IDLE.
REQ-027 FAULT: error=1; hold until err_clr=1, then go to IDLE.
REQ-028 start and abort are ignored while in FAULT.
REQ-029 abort=1 in LAUNCH or WAIT: go to IDLE next cycle, with no done, no frame_count change, and no further stage_start.
REQ-030 abort has priority over done and timeout.
REQ-031 abort in the LAUNCH cycle does not suppress that cycle's stage_start pulse.
REQ-032 start while busy or in FINISH is ignored; it is not queued.
REQ-033 Minimum frame latency, with every stage answering on its first WAIT cycle: start sampled at edge 0, stage_start[0] high in cycle 1, done high in cycle 2*NUM_STAGES+1.

Reset
REQ-034 reset_n=0 immediately and asynchronously forces: IDLE, idx=0, wd=0, err_stage=0, frame_count=0, all outputs 0.
REQ-035 Reset deassertion is used synchronized by the integrator; the block takes no action until the first clk edge after reset_n=1.
REQ-036 Reset mid-frame abandons the frame; no done pulse and no further stage_start pulses.

Verification
REQ-037 NUM_STAGES=3; stage models answer 5 cycles after their start; start at cycle 0 -> stage_start[0]@1, [1]@7, [2]@13, done@19, frame_count=1.
REQ-038 TIMEOUT_CYCLES=8; stage 1 never answers -> error=1 at cycle 8 of stage 1 WAIT, err_stage=1, no done; err_clr -> IDLE, error=0.
REQ-039 stage_done[idx] on the same cycle as wd=TIMEOUT_CYCLES-1 -> advance/finish, error stays 0.
REQ-040 abort during stage 1 WAIT -> IDLE next cycle, no stage_start[2], frame_count unchanged; new start runs a full frame.
REQ-041 Spurious stage_done[2] during stage 0 WAIT, plus start pulses while busy -> both ignored, exactly one done per frame.
REQ-042 FRAME_W=2; run 5 frames -> frame_count 1,2,3,0,1; assert reset_n=0 mid-frame -> all outputs 0 asynchronously.
